// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Shared constants and helpers for the 1000BASE-X transmit PCS:
//   - K-octet constants for the supported ordered sets (/I/, /S/, /T/, /R/, /V/)
//   - data octets used as the second code group of an idle (D5.6, D16.2)
//   - state encoding of the transmit code-group FSM
//   - small pure helpers (supported-K check, sub-block ones counters)
// -----------------------------------------------------------------------------
package pcs_pkg;

  // Control octets as presented with k=1
  localparam logic [7:0] K28_5 = 8'hBC;  // /I/ comma
  localparam logic [7:0] K27_7 = 8'hFB;  // /S/
  localparam logic [7:0] K29_7 = 8'hFD;  // /T/
  localparam logic [7:0] K23_7 = 8'hF7;  // /R/
  localparam logic [7:0] K30_7 = 8'hFE;  // /V/

  // Second code group of /I1/ and /I2/
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  // State names describe the code group currently on the output
  typedef enum logic [1:0] {
    SINGLE  = 2'd0,
    ALIGN_R = 2'd1,
    IDLE_K  = 2'd2,
    IDLE_D  = 2'd3
  } tx_state_e;

  // True for every control octet the transmitter knows how to send
  function automatic logic is_supported_k(input logic [7:0] octet);
    logic ok;
    case (octet)
      K28_5, K27_7, K29_7, K23_7, K30_7: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Number of ones in a 6-bit sub-block (3 means neutral)
  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // Number of ones in a 4-bit sub-block (2 means neutral)
  function automatic logic [2:0] ones4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/enc_8b10b.sv
// -----------------------------------------------------------------------------
// enc_8b10b
// Purely combinational 8b/10b encoder (5b/6b + 3b/4b with per-sub-block
// running disparity). Shared with the autonegotiation /C/ path.
// Ports:
//   octet  [7:0] in  : HGF EDCBA, bits [4:0] = x, bits [7:5] = y
//   k            in  : 1 = control code group K.x.y
//   rd_in        in  : running disparity before the code group (1 = positive)
//   code   [9:0] out : abcdei fghj, bit 9 = a (first transmitted)
//   rd_out       out : running disparity after the code group
// -----------------------------------------------------------------------------
module enc_8b10b
  import pcs_pkg::*;
(
  input  logic [7:0] octet,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k28;
  logic [5:0] six_neg;
  logic       six_alt;
  logic [5:0] six;
  logic       rd_mid;
  logic [3:0] four_neg;
  logic       four_alt;
  logic [3:0] four;
  logic       a7;

  assign x   = octet[4:0];
  assign y   = octet[7:5];
  assign k28 = k && (x == 5'd28);

  // 5b/6b: RD- form from the table, complemented under RD+ when the
  // sub-block has an alternate (unbalanced, or the D.07 / K.28 specials)
  always_comb begin
    six_neg = 6'b000000;
    case (x)
      5'd0:  six_neg = 6'b100111;
      5'd1:  six_neg = 6'b011101;
      5'd2:  six_neg = 6'b101101;
      5'd3:  six_neg = 6'b110001;
      5'd4:  six_neg = 6'b110101;
      5'd5:  six_neg = 6'b101001;
      5'd6:  six_neg = 6'b011001;
      5'd7:  six_neg = 6'b111000;
      5'd8:  six_neg = 6'b111001;
      5'd9:  six_neg = 6'b100101;
      5'd10: six_neg = 6'b010101;
      5'd11: six_neg = 6'b110100;
      5'd12: six_neg = 6'b001101;
      5'd13: six_neg = 6'b101100;
      5'd14: six_neg = 6'b011100;
      5'd15: six_neg = 6'b010111;
      5'd16: six_neg = 6'b011011;
      5'd17: six_neg = 6'b100011;
      5'd18: six_neg = 6'b010011;
      5'd19: six_neg = 6'b110010;
      5'd20: six_neg = 6'b001011;
      5'd21: six_neg = 6'b101010;
      5'd22: six_neg = 6'b011010;
      5'd23: six_neg = 6'b111010;
      5'd24: six_neg = 6'b110011;
      5'd25: six_neg = 6'b100110;
      5'd26: six_neg = 6'b010110;
      5'd27: six_neg = 6'b110110;
      5'd28: six_neg = 6'b001110;
      5'd29: six_neg = 6'b101110;
      5'd30: six_neg = 6'b011110;
      5'd31: six_neg = 6'b101011;
      default: six_neg = 6'b000000;
    endcase
    // K.28 carries the comma-forming sub-block instead of D.28
    if (k28) begin
      six_neg = 6'b001111;
    end else begin
      six_neg = six_neg;
    end
    six_alt = (ones6(six_neg) != 3'd3) || ((x == 5'd7) && !k28);
    six     = (six_alt && rd_in) ? ~six_neg : six_neg;
    rd_mid  = rd_in ^ (ones6(six_neg) != 3'd3);
  end

  // 3b/4b: indexed by the disparity left after the 6b sub-block; every
  // K sub-block has two forms, D ones only when unbalanced or x.3
  always_comb begin
    four_neg = 4'b0000;
    four_alt = 1'b0;
    a7 = (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
         ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    if (k) begin
      case (y)
        3'd0: four_neg = 4'b1011;
        3'd1: four_neg = 4'b0110;
        3'd2: four_neg = 4'b1010;
        3'd3: four_neg = 4'b1100;
        3'd4: four_neg = 4'b1101;
        3'd5: four_neg = 4'b0101;
        3'd6: four_neg = 4'b1001;
        3'd7: four_neg = 4'b0111;
        default: four_neg = 4'b0000;
      endcase
      four_alt = 1'b1;
    end else begin
      case (y)
        3'd0: four_neg = 4'b1011;
        3'd1: four_neg = 4'b1001;
        3'd2: four_neg = 4'b0101;
        3'd3: four_neg = 4'b1100;
        3'd4: four_neg = 4'b1101;
        3'd5: four_neg = 4'b1010;
        3'd6: four_neg = 4'b0110;
        // A7 avoids a run of five equal bits across the sub-block boundary
        3'd7: four_neg = a7 ? 4'b0111 : 4'b1110;
        default: four_neg = 4'b0000;
      endcase
      four_alt = (ones4(four_neg) != 3'd2) || (y == 3'd3);
    end
    four   = (four_alt && rd_mid) ? ~four_neg : four_neg;
    rd_out = rd_mid ^ (ones4(four_neg) != 3'd2);
    code   = {six, four};
  end

endmodule

// File: rtl/pcs_tx_code_group.sv
// -----------------------------------------------------------------------------
// pcs_tx_code_group
// Transmit code-group stage of the 1000BASE-X PCS. Captures one ordered set
// per TX_OSET_indicate handshake and expands it into one (data, /S/, /T/, /R/,
// /V/) or two (/I/) 8b/10b code groups, inserting one /R/ ahead of an /I/
// that would otherwise start on an odd position.
// Ports:
//   GTX_CLK               in  : clock, rising edge
//   RESET                 in  : synchronous, active-low reset
//   tx_o_set        [7:0] in  : ordered-set octet from the upstream FSM
//   tx_o_set_k            in  : 1 = tx_o_set is a control octet
//   tx_code_group   [9:0] out : registered code group, bit 9 = a
//   tx_even               out : 1 while the current group is on an even position
//   TX_OSET_indicate      out : 1 while the last group of the current set is driven
//   tx_disparity          out : running disparity after the current group
// Parameter:
//   INVALID_K : control octet sent for any unsupported K octet (/V/)
// -----------------------------------------------------------------------------
module pcs_tx_code_group
  import pcs_pkg::*;
#(
  parameter logic [7:0] INVALID_K = 8'hFE
) (
  input  logic       GTX_CLK,
  input  logic       RESET,
  input  logic [7:0] tx_o_set,
  input  logic       tx_o_set_k,
  output logic [9:0] tx_code_group,
  output logic       tx_even,
  output logic       TX_OSET_indicate,
  output logic       tx_disparity
);

  tx_state_e  state_q, state_d;
  logic [9:0] code_q, code_d;
  logic       even_q, even_d;
  logic       ind_q, ind_d;
  logic       rd_q, rd_d;

  // Decision for a newly captured set
  logic [7:0] cap_octet;
  logic       cap_k;
  tx_state_e  cap_state;
  logic       cap_ind;

  // Encoder operands for the next code group
  logic [7:0] enc_octet;
  logic       enc_k;
  logic [9:0] enc_code;
  logic       enc_rd;

  // Decode the set on the inputs into its first code group and follow-on state
  always_comb begin
    cap_octet = tx_o_set;
    cap_k     = tx_o_set_k;
    cap_state = SINGLE;
    cap_ind   = 1'b1;
    if (tx_o_set_k && (tx_o_set == K28_5)) begin
      cap_k   = 1'b1;
      cap_ind = 1'b0;
      // even_q = 1 means the next group lands on an odd position
      if (even_q) begin
        cap_octet = K23_7;
        cap_state = ALIGN_R;
      end else begin
        cap_octet = K28_5;
        cap_state = IDLE_K;
      end
    end else if (tx_o_set_k) begin
      cap_octet = is_supported_k(tx_o_set) ? tx_o_set : INVALID_K;
    end else begin
      cap_octet = tx_o_set;
    end
  end

  // Next code group and state from the group currently being driven
  always_comb begin
    enc_octet = cap_octet;
    enc_k     = cap_k;
    state_d   = cap_state;
    ind_d     = cap_ind;
    case (state_q)
      ALIGN_R: begin
        enc_octet = K28_5;
        enc_k     = 1'b1;
        state_d   = IDLE_K;
        ind_d     = 1'b0;
      end
      IDLE_K: begin
        // rd_q is the disparity after K28.5, the inverse of that at capture
        enc_octet = rd_q ? D16_2 : D5_6;
        enc_k     = 1'b0;
        state_d   = IDLE_D;
        ind_d     = 1'b1;
      end
      SINGLE, IDLE_D: begin
        enc_octet = cap_octet;
        enc_k     = cap_k;
        state_d   = cap_state;
        ind_d     = cap_ind;
      end
      default: begin
        enc_octet = cap_octet;
        enc_k     = cap_k;
        state_d   = cap_state;
        ind_d     = cap_ind;
      end
    endcase
    code_d = enc_code;
    rd_d   = enc_rd;
    even_d = ~even_q;
  end

  enc_8b10b u_enc (
    .octet  (enc_octet),
    .k      (enc_k),
    .rd_in  (rd_q),
    .code   (enc_code),
    .rd_out (enc_rd)
  );

  // Output and FSM registers; reset abandons any set in progress
  always_ff @(posedge GTX_CLK) begin
    if (!RESET) begin
      state_q <= SINGLE;
      code_q  <= 10'b0000000000;
      even_q  <= 1'b0;
      ind_q   <= 1'b1;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      even_q  <= even_d;
      ind_q   <= ind_d;
      rd_q    <= rd_d;
    end
  end

  assign tx_code_group    = code_q;
  assign tx_even          = even_q;
  assign TX_OSET_indicate = ind_q;
  assign tx_disparity     = rd_q;

endmodule

// File: tb/tb_pcs_tx_code_group.sv
// -----------------------------------------------------------------------------
// Testbench for pcs_tx_code_group: directed sequence with literal expected
// code groups, then a randomized stream checked against a table-driven
// reference model. Expected groups go into a queue; a monitor pops one per
// clock and compares.
// -----------------------------------------------------------------------------
module tb_pcs_tx_code_group;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] tx_o_set;
  logic       tx_o_set_k;
  logic [9:0] tx_code_group;
  logic       tx_even;
  logic       TX_OSET_indicate;
  logic       tx_disparity;

  always #5 clk = ~clk;

  pcs_tx_code_group dut (
    .GTX_CLK          (clk),
    .RESET            (RESET),
    .tx_o_set         (tx_o_set),
    .tx_o_set_k       (tx_o_set_k),
    .tx_code_group    (tx_code_group),
    .tx_even          (tx_even),
    .TX_OSET_indicate (TX_OSET_indicate),
    .tx_disparity     (tx_disparity)
  );

  typedef struct packed {
    logic [9:0] code;
    logic       even;
    logic       ind;
    logic       rd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   grp    = 0;

  // reference model state
  logic m_rd;
  int   m_pos;

  // 5b/6b table: {RD- column, RD+ column}
  function automatic logic [11:0] t6(input logic [4:0] x);
    case (x)
      5'd0:  return {6'b100111, 6'b011000};
      5'd1:  return {6'b011101, 6'b100010};
      5'd2:  return {6'b101101, 6'b010010};
      5'd3:  return {6'b110001, 6'b110001};
      5'd4:  return {6'b110101, 6'b001010};
      5'd5:  return {6'b101001, 6'b101001};
      5'd6:  return {6'b011001, 6'b011001};
      5'd7:  return {6'b111000, 6'b000111};
      5'd8:  return {6'b111001, 6'b000110};
      5'd9:  return {6'b100101, 6'b100101};
      5'd10: return {6'b010101, 6'b010101};
      5'd11: return {6'b110100, 6'b110100};
      5'd12: return {6'b001101, 6'b001101};
      5'd13: return {6'b101100, 6'b101100};
      5'd14: return {6'b011100, 6'b011100};
      5'd15: return {6'b010111, 6'b101000};
      5'd16: return {6'b011011, 6'b100100};
      5'd17: return {6'b100011, 6'b100011};
      5'd18: return {6'b010011, 6'b010011};
      5'd19: return {6'b110010, 6'b110010};
      5'd20: return {6'b001011, 6'b001011};
      5'd21: return {6'b101010, 6'b101010};
      5'd22: return {6'b011010, 6'b011010};
      5'd23: return {6'b111010, 6'b000101};
      5'd24: return {6'b110011, 6'b001100};
      5'd25: return {6'b100110, 6'b100110};
      5'd26: return {6'b010110, 6'b010110};
      5'd27: return {6'b110110, 6'b001001};
      5'd28: return {6'b001110, 6'b001110};
      5'd29: return {6'b101110, 6'b010001};
      5'd30: return {6'b011110, 6'b100001};
      default: return {6'b101011, 6'b010100};
    endcase
  endfunction

  // 3b/4b data table {RD-, RD+}; alt7 selects the A7 row for y=7
  function automatic logic [7:0] t4d(input logic [2:0] y, input logic alt7);
    case (y)
      3'd0: return {4'b1011, 4'b0100};
      3'd1: return {4'b1001, 4'b1001};
      3'd2: return {4'b0101, 4'b0101};
      3'd3: return {4'b1100, 4'b0011};
      3'd4: return {4'b1101, 4'b0010};
      3'd5: return {4'b1010, 4'b1010};
      3'd6: return {4'b0110, 4'b0110};
      default: return alt7 ? {4'b0111, 4'b1000} : {4'b1110, 4'b0001};
    endcase
  endfunction

  // 3b/4b control table {RD-, RD+}
  function automatic logic [7:0] t4k(input logic [2:0] y);
    case (y)
      3'd0: return {4'b1011, 4'b0100};
      3'd1: return {4'b0110, 4'b1001};
      3'd2: return {4'b1010, 4'b0101};
      3'd3: return {4'b1100, 4'b0011};
      3'd4: return {4'b1101, 4'b0010};
      3'd5: return {4'b0101, 4'b1010};
      3'd6: return {4'b1001, 4'b0110};
      default: return {4'b0111, 4'b1000};
    endcase
  endfunction

  function automatic int ones(input logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(v[i]);
    return n;
  endfunction

  // Reference encoder: pick table column by current RD, update RD by weight
  task automatic enc_m(input logic [7:0] b, input logic k, input logic rd_in,
                       output logic [9:0] code, output logic rd_out);
    logic [11:0] e6;
    logic [7:0]  e4;
    logic [5:0]  s6;
    logic [3:0]  s4;
    logic [4:0]  x;
    logic [2:0]  y;
    logic        r;
    logic        alt7;
    x = b[4:0];
    y = b[7:5];
    if (k && x == 5'd28) e6 = {6'b001111, 6'b110000};
    else                 e6 = t6(x);
    s6 = rd_in ? e6[5:0] : e6[11:6];
    r  = rd_in;
    if (ones(s6) > 3) r = 1'b1;
    else if (ones(s6) < 3) r = 1'b0;
    alt7 = (!r && (x inside {5'd17, 5'd18, 5'd20})) ||
           ( r && (x inside {5'd11, 5'd13, 5'd14}));
    e4 = k ? t4k(y) : t4d(y, alt7);
    s4 = r ? e4[3:0] : e4[7:4];
    if (ones({2'b00, s4}) > 2) r = 1'b1;
    else if (ones({2'b00, s4}) < 2) r = 1'b0;
    code   = {s6, s4};
    rd_out = r;
  endtask

  task automatic push_lit(input logic [9:0] code, input logic even,
                          input logic ind, input logic rd);
    exp_t e;
    e.code = code; e.even = even; e.ind = ind; e.rd = rd;
    exp_q.push_back(e);
  endtask

  task automatic push_m(input logic [7:0] b, input logic k, input logic ind);
    logic [9:0] c;
    logic       nrd;
    enc_m(b, k, m_rd, c, nrd);
    m_rd = nrd;
    push_lit(c, (m_pos % 2 == 0), ind, m_rd);
    m_pos++;
  endtask

  // Predict every code group of one ordered set; returns the group count
  task automatic model_set(input logic [7:0] b, input logic k, output int n);
    logic cap_rd;
    if (k && b == 8'hBC) begin
      n = 2;
      if (m_pos % 2 == 1) begin
        push_m(8'hF7, 1'b1, 1'b0);
        n = 3;
      end
      cap_rd = m_rd;
      push_m(8'hBC, 1'b1, 1'b0);
      push_m(cap_rd ? 8'hC5 : 8'h50, 1'b0, 1'b1);
    end else begin
      n = 1;
      if (k && !(b inside {8'hFB, 8'hFD, 8'hF7, 8'hFE})) push_m(8'hFE, 1'b1, 1'b1);
      else push_m(b, k, 1'b1);
    end
  endtask

  // Present a set for one capture, then scribble don't-care inputs while held
  task automatic hold(input logic [7:0] b, input logic k, input int n);
    tx_o_set   = b;
    tx_o_set_k = k;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      tx_o_set   = 8'($urandom);
      tx_o_set_k = 1'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic send_m(input logic [7:0] b, input logic k);
    int n;
    model_set(b, k, n);
    hold(b, k, n);
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b0;
    for (int i = 0; i < n; i++) begin
      tx_o_set   = 8'($urandom);
      tx_o_set_k = 1'($urandom);
      push_lit(10'b0000000000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
    end
    RESET = 1'b1;
    m_rd  = 1'b0;
    m_pos = 0;
  endtask

  // Monitor: one code group per clock, sampled just after the edge
  always @(posedge clk) begin
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL underflow grp %0d: got code=%b with no expected group", grp, tx_code_group);
    end else begin
      mon_e = exp_q.pop_front();
      if ({tx_code_group, tx_even, TX_OSET_indicate, tx_disparity} !== mon_e) begin
        errors++;
        $display("FAIL grp %0d: got code=%b even=%b ind=%b rd=%b, want code=%b even=%b ind=%b rd=%b",
                 grp, tx_code_group, tx_even, TX_OSET_indicate, tx_disparity,
                 mon_e.code, mon_e.even, mon_e.ind, mon_e.rd);
      end
    end
    grp++;
  end

  initial begin
    int r;
    logic [7:0] b;
    logic [7:0] kset [4];
    kset[0] = 8'hFB; kset[1] = 8'hFD; kset[2] = 8'hF7; kset[3] = 8'hFE;
    RESET = 1'b0;
    tx_o_set = 8'h00;
    tx_o_set_k = 1'b0;

    // ---------------- directed, literal expectations ----------------
    do_reset(3);
    push_lit(10'b0011111010, 1'b1, 1'b0, 1'b1);   // K28.5- after reset
    push_lit(10'b1001000101, 1'b0, 1'b1, 1'b0);   // D16.2
    hold(8'hBC, 1'b1, 2);
    push_lit(10'b1001110100, 1'b1, 1'b1, 1'b0);   // D0.0-
    hold(8'h00, 1'b0, 1);
    push_lit(10'b1100011011, 1'b0, 1'b1, 1'b1);   // D3.0- forces RD+
    hold(8'h03, 1'b0, 1);
    push_lit(10'b1100000101, 1'b1, 1'b0, 1'b0);   // K28.5+
    push_lit(10'b1010010110, 1'b0, 1'b1, 1'b0);   // D5.6
    hold(8'hBC, 1'b1, 2);
    push_lit(10'b1101101000, 1'b1, 1'b1, 1'b0);   // /S/ at even
    hold(8'hFB, 1'b1, 1);
    push_lit(10'b1001110100, 1'b0, 1'b1, 1'b0);   // data after /S/
    hold(8'h00, 1'b0, 1);
    push_lit(10'b1011101000, 1'b1, 1'b1, 1'b0);   // /T/
    hold(8'hFD, 1'b1, 1);
    push_lit(10'b1110101000, 1'b0, 1'b0, 1'b0);   // inserted /R/ (odd slot)
    push_lit(10'b0011111010, 1'b1, 1'b0, 1'b1);   // K28.5 on even
    push_lit(10'b1001000101, 1'b0, 1'b1, 1'b0);
    hold(8'hBC, 1'b1, 3);
    push_lit(10'b0111101000, 1'b1, 1'b1, 1'b0);   // unsupported K -> K30.7-
    hold(8'h00, 1'b1, 1);
    push_lit(10'b1001110100, 1'b0, 1'b1, 1'b0);
    hold(8'h00, 1'b0, 1);
    push_lit(10'b0011111010, 1'b1, 1'b0, 1'b1);   // K28.5, then reset in IDLE_K
    hold(8'hBC, 1'b1, 1);
    do_reset(2);
    push_lit(10'b1001110100, 1'b1, 1'b1, 1'b0);
    hold(8'h00, 1'b0, 1);
    push_lit(10'b1110101000, 1'b0, 1'b0, 1'b0);   // /R/, then reset in ALIGN_R
    hold(8'hBC, 1'b1, 1);
    do_reset(2);

    // ---------------- reference-model phase ----------------
    for (int i = 0; i < 256; i++) send_m(8'(i), 1'b0);   // back-to-back data burst
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 3) do_reset($urandom_range(1, 2));
      r = $urandom_range(0, 99);
      if (r < 45)      send_m(8'($urandom), 1'b0);
      else if (r < 70) send_m(8'hBC, 1'b1);
      else if (r < 88) send_m(kset[$urandom_range(0, 3)], 1'b1);
      else begin
        b = 8'($urandom);
        send_m(b, 1'b1);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected groups never seen, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_tx_code_group.md
# pcs_tx_code_group

Transmit code-group stage of the 1000BASE-X PCS, directly downstream of the transmit ordered-set FSM (`transmisor_1`). It captures one ordered set per `TX_OSET_indicate` handshake and expands it into one or two 8b/10b code groups. It tracks running disparity and even/odd code-group position, and feeds 10-bit code groups to the serializer.

## Interface
Parameters:
- `INVALID_K`, default `8'hFE`: K code (K30.7, /V/) emitted in place of any unsupported K octet.

Ports:
- `GTX_CLK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `tx_o_set` in 8: ordered-set octet from the upstream FSM. Either a data octet, or a K octet: BC=/I/ (K28.5), FB=/S/ (K27.7), FD=/T/ (K29.7), F7=/R/ (K23.7), FE=/V/ (K30.7).
- `tx_o_set_k` in 1: 1 means `tx_o_set` is a control (K) octet.
- `tx_code_group` out 10: encoded code group. Bit 9 = a (first transmitted), bit 0 = j.
- `tx_even` out 1: 1 while the current code group occupies an even position.
- `TX_OSET_indicate` out 1: 1 while the last code group of the current ordered set is driven.
- `tx_disparity` out 1: running disparity after the current code group (1 = positive).

## Operation
- Capture rule: `tx_o_set`/`tx_o_set_k` are sampled at every rising edge that ends a cycle with `TX_OSET_indicate`=1. The first code group of the new set is driven from that edge. There are no bubbles.
- Single-group sets (data, /S/, /T/, /R/, /V/): one code group, with `TX_OSET_indicate`=1 during it.
- /I/ (k=1, BC): two code groups, K28.5 then Dx.
  - RD positive at capture: /I1/ = K28.5, D5.6.
  - RD negative at capture: /I2/ = K28.5, D16.2.
  - Either way, RD is negative after the idle.
  - `TX_OSET_indicate`=1 only on the D code group.
- Alignment: K28.5 of /I/ must land on an even position. If /I/ is captured while the next position is odd:
  - one K23.7 (/R/) is inserted first, with `TX_OSET_indicate`=0;
  - then K28.5 and Dx follow. Dx is selected by RD after the /R/.
- Invalid K (k=1, octet not in the list above): encode `INVALID_K`.
- FSM states:
  - `SINGLE`: any single-group set.
  - `ALIGN_R`: inserted /R/ → `IDLE_K`.
  - `IDLE_K`: K28.5 → `IDLE_D`.
  - `IDLE_D`: D5.6/D16.2, indicate=1.
  - From `SINGLE` or `IDLE_D`, the next state follows the newly captured set.
- Position: `tx_even` toggles on every code group, including inserted /R/.
- Encoder rules (standard 5b/6b + 3b/4b, with per-sub-block disparity):
  - A7 alternate for D.x.7 when (RD- and x∈{17,18,20}) or (RD+ and x∈{11,13,14}).
  - Neutral sub-blocks keep RD.
- Reset (while `RESET`=0, all registered):
  - `tx_code_group`=10'b0, `tx_even`=0, `TX_OSET_indicate`=1, `tx_disparity`=0 (negative), state `SINGLE`.
  - The first edge with `RESET`=1 captures the first set, at an even position.
- Reset mid-idle or mid-/R/: abandon the set. The next edge shows reset values. No partial idle is completed.

## Timing
- Latency: one cycle from the capture edge to the code group on `tx_code_group`.
- `tx_code_group`, `tx_even`, `TX_OSET_indicate` and `tx_disparity` are all registered and change together.
- Throughput:
  - data: 1 octet/cycle;
  - /I/: 2 cycles;
  - /I/ with alignment: 3 cycles.
- Inputs are don't-care in cycles where `TX_OSET_indicate`=0.

## Structure
- Shared package `pcs_pkg`:
  - K octet constants (`K28_5`=BC, `K27_7`=FB, `K29_7`=FD, `K23_7`=F7, `K30_7`=FE);
  - `D5_6`=C5, `D16_2`=50;
  - FSM state encoding.
- Sub-module `enc_8b10b`: combinational (octet, k, rd_in) → (code[9:0], rd_out). It is shared with the future autonegotiation /C/ path. The FSM and registers stay in the top.

## Test plan
- Reset release, then /I/ stream from RD-:
  - codes 0011111010 (K28.5-), 1001000101 (D16.2+);
  - `tx_even` 1,0; indicate 0,1; `tx_disparity` 1,0.
- /I/ captured with RD+ (after forcing RD+ via D3.0 = 1100011011):
  - codes 1100000101 (K28.5+), 1010010110 (D5.6);
  - RD negative afterwards.
- Data D0.0 from RD- → 1001110100, RD stays negative. A back-to-back data burst holds indicate=1 every cycle and toggles `tx_even`.
- /S/ at even from RD- → 1101101000, then data. /T/ from RD- → 1011101000.
- /I/ captured with next position odd:
  - codes 1110101000 (/R/, indicate 0), then K28.5, then Dx (indicate 1);
  - K28.5 has `tx_even`=1.
- Boundary cases:
  - k=1 with octet 00 → 0111101000 (K30.7-).
  - `RESET`=0 asserted during `IDLE_K` → next cycle shows code 0, indicate=1, even=0, RD=0.
